param_slew_limiter: RTL and testbench
=====================================

Name: param_slew_limiter

Overview:
- Downstream of the CPU audio parameter register bank, on the same clock.
- Takes NCH raw 32-bit parameter words written by firmware and moves a smoothed copy of each toward its target once per audio sample strobe.
- Removes zipper noise when the DSP datapath (oscillator increments, gains) sees parameter steps.
- Serviced round-robin, one channel per clock, through a single shared adder.

Parameters:
- WIDTH, 32, bit width of each parameter word; unsigned.
- NCH, 15, number of channels; matches the register bank's parameter outputs.
- SHIFT, 4, smoothing coefficient; step = (target - current) >>> SHIFT.

Ports:
- i_wb_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_target  in  NCH*WIDTH  flattened target words; channel k is bits [k*WIDTH +: WIDTH].
- i_sample_strobe  in  1  one-cycle pulse per audio sample; starts a sweep.
- o_param  out  NCH*WIDTH  flattened smoothed words, same packing as i_target.
- o_busy  out  1  high while a sweep is in progress.
- o_done  out  1  one-cycle pulse after the last channel of a sweep is updated.
- o_overrun  out  1  one-cycle pulse when a strobe arrives while busy.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - all o_param words, o_busy, o_done and o_overrun go to 0;
  - state goes to IDLE; the channel index and the pending flag clear.
  - Reset mid-sweep abandons the sweep with no o_done.
- State machine: IDLE and RUN.
  - IDLE, strobe sampled at edge E0: go to RUN, idx=0, o_busy=1.
  - RUN, each edge: update channel idx, then idx+1.
  - At edge E0+NCH the last channel updates. If pending=0, go to IDLE, o_busy=0. o_done is high for the cycle after E0+NCH.
  - Channel k therefore changes at edge E0+1+k.
- Targets are read live from i_target at the edge where each channel is processed; they are not snapshotted at the strobe.
- Arithmetic per channel, signed WIDTH+1 bits:
  - diff = target - current; step = diff >>> SHIFT (arithmetic shift).
  - If step==0 and diff!=0: step = +1 for diff>0, -1 for diff<0, so the value always converges exactly.
  - current <= current + step.
  - The result cannot overshoot or wrap, because |step| <= |diff|.
  - diff==0 leaves the channel unchanged.
- Strobe while RUN:
  - pending <= 1 and o_overrun pulses on the next cycle.
  - At the end of the current sweep, o_done still pulses. A new sweep then starts immediately (idx=0, stay in RUN) and pending clears.
  - Further strobes during the same sweep are absorbed: one pending only, but o_overrun pulses for each.
- Strobe on the same edge as the last update counts as overrun (pending set).
- A strobe held high for several cycles is treated as repeated strobes; the source is responsible for pulses.

Optional Feature:
- Macro: PARAM_SLEW_LIMITER_BYPASS_EN.
- Defined:
  - Adds input port i_bypass (NCH bits).
  - When bit k is 1 at the edge channel k is processed, current <= target directly, with no slew.
  - Bypass obeys the same sweep timing; it is not asynchronous.
- Undefined: the port does not exist and every channel always slews.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_target all 0xFFFF_FFFF -> all o_param=0, o_busy=0, o_done=0.
- Upward ramp (WIDTH=32, NCH=4, SHIFT=4): ch0 target 0x100, one strobe -> ch0=0x10 at E0+1, o_done pulse after E0+4. Second strobe -> 0x1F.
- Minimum step: ch1 from 0, target 0x5 -> ch1 = 1,2,3,4,5 over 5 sweeps, then stays 5 on a 6th sweep.
- Downward: ch2 settled at 0x100, target 0 -> 0xF0 after one sweep, then 0xE1.
- Overrun: strobe, then strobe again 2 cycles later ->
  - o_overrun pulses once;
  - o_done pulses twice, 4 cycles apart;
  - o_busy stays high for 8 consecutive cycles.
- Reset mid-sweep: assert i_rst_n=0 at E0+2 -> all outputs 0, no o_done. The next strobe behaves as in the upward-ramp case.

Source files
------------

// File: rtl/param_slew_limiter_if.sv
// Bundles the target words, the sample strobe and the smoothed outputs of param_slew_limiter.
// When PARAM_SLEW_LIMITER_BYPASS_EN is defined, the bundle also carries the per-channel bypass mask i_bypass.
interface param_slew_limiter_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 15
);
    logic [NCH*WIDTH-1:0] i_target;
    logic                 i_sample_strobe;
`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
    logic [NCH-1:0]       i_bypass;
`endif
    logic [NCH*WIDTH-1:0] o_param;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_overrun;

`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
    modport master (
        output i_target, i_sample_strobe, i_bypass,
        input  o_param, o_busy, o_done, o_overrun
    );
    modport slave (
        input  i_target, i_sample_strobe, i_bypass,
        output o_param, o_busy, o_done, o_overrun
    );
`else
    modport master (
        output i_target, i_sample_strobe,
        input  o_param, o_busy, o_done, o_overrun
    );
    modport slave (
        input  i_target, i_sample_strobe,
        output o_param, o_busy, o_done, o_overrun
    );
`endif
endinterface

// File: rtl/param_slew_limiter.sv
// Round-robin slew limiter: each sample strobe moves every smoothed parameter toward its target by one shared-adder step.
// Optional PARAM_SLEW_LIMITER_BYPASS_EN lets a channel jump straight to its target when its i_bypass bit is set.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for i_sample_strobe; no channel is touched
//   S_RUN  | sweep in progress, channel r_idx is updated on every edge
module param_slew_limiter #(
    parameter int WIDTH = 32,
    parameter int NCH   = 15,
    parameter int SHIFT = 4
) (
    input  logic                  i_wb_clk,
    input  logic                  i_rst_n,
    param_slew_limiter_if.slave   bus
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_pending;
    logic               w_pending_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_upd_en;
    logic               w_last;

    logic [WIDTH-1:0]   r_param  [NCH];
    logic [WIDTH-1:0]   w_target [NCH];
    logic [WIDTH-1:0]   w_cur;
    logic [WIDTH-1:0]   w_tgt;
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH:0] w_step_sh;
    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_slew;
    logic [WIDTH-1:0]   w_next;

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign w_target[g]                 = bus.i_target[g*WIDTH +: WIDTH];
        assign bus.o_param[g*WIDTH +: WIDTH] = r_param[g];
    end

    assign bus.o_busy    = (r_state == S_RUN);
    assign bus.o_done    = r_done;
    assign bus.o_overrun = r_overrun;

    assign w_last = (r_idx == IDX_W'(NCH - 1));

    always_ff @(posedge i_wb_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // A strobe on the final edge of a sweep is folded into pending, so it restarts the sweep directly.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = 1'b0;
        w_upd_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_sample_strobe) begin
                    w_state_nxt = S_RUN;
                    w_idx_nxt   = '0;
                end
            end
            S_RUN: begin
                w_upd_en = 1'b1;
                if (bus.i_sample_strobe) begin
                    w_overrun_nxt = 1'b1;
                    w_pending_nxt = 1'b1;
                end
                if (w_last) begin
                    w_done_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    if (r_pending || bus.i_sample_strobe) begin
                        w_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_cur     = r_param[r_idx];
    assign w_tgt     = w_target[r_idx];
    assign w_diff    = $signed({1'b0, w_tgt}) - $signed({1'b0, w_cur});
    assign w_step_sh = w_diff >>> SHIFT;

    // Force a unit step once the shifted difference vanishes so every channel lands exactly on target.
    always_comb begin
        w_step = w_step_sh[WIDTH-1:0];
        if ((w_step_sh == '0) && (w_diff != '0)) begin
            w_step = w_diff[WIDTH] ? '1 : WIDTH'(1);
        end
    end

    assign w_slew = w_cur + w_step;

`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
    assign w_next = bus.i_bypass[r_idx] ? w_tgt : w_slew;
`else
    assign w_next = w_slew;
`endif

    always_ff @(posedge i_wb_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_param[k] <= '0;
            end
        end else if (w_upd_en) begin
            r_param[r_idx] <= w_next;
        end
    end
endmodule

// File: tb/tb_param_slew_limiter.sv
// Directed and randomized bench for param_slew_limiter with a sweep-level reference model.
// Drives i_bypass only when PARAM_SLEW_LIMITER_BYPASS_EN is defined.
module tb_param_slew_limiter;
    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SHIFT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    param_slew_limiter_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    param_slew_limiter #(.WIDTH(WIDTH), .NCH(NCH), .SHIFT(SHIFT)) dut (
        .i_wb_clk (clk),
        .i_rst_n  (rst_n),
        .bus      (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] m_param [NCH];
    bit               m_active;
    bit               m_pending;
    bit               m_done;
    bit               m_overrun;
    int               m_next_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step is floor(diff / 2^SHIFT), with a unit step whenever that floor is zero but diff is not.
    function automatic logic [WIDTH-1:0] slew_ref(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        longint d;
        longint s;
        longint q;
        q = longint'(1) << SHIFT;
        d = longint'({32'b0, tgt}) - longint'({32'b0, cur});
        if (d >= 0) s = d / q;
        else        s = -((-d + q - 1) / q);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return WIDTH'(longint'({32'b0, cur}) + s);
    endfunction

    task automatic model_edge();
        logic [WIDTH-1:0] tgt;
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) m_param[k] = '0;
            m_active  = 0;
            m_pending = 0;
            m_done    = 0;
            m_overrun = 0;
            m_next_ch = 0;
        end else begin
            m_done    = 0;
            m_overrun = 0;
            if (m_active) begin
                tgt = bus.i_target[m_next_ch*WIDTH +: WIDTH];
`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
                if (bus.i_bypass[m_next_ch]) m_param[m_next_ch] = tgt;
                else m_param[m_next_ch] = slew_ref(m_param[m_next_ch], tgt);
`else
                m_param[m_next_ch] = slew_ref(m_param[m_next_ch], tgt);
`endif
                if (bus.i_sample_strobe) begin
                    m_overrun = 1;
                    m_pending = 1;
                end
                m_next_ch++;
                if (m_next_ch == NCH) begin
                    m_done    = 1;
                    m_next_ch = 0;
                    if (m_pending) m_pending = 0;
                    else           m_active  = 0;
                end
            end else if (bus.i_sample_strobe) begin
                m_active  = 1;
                m_next_ch = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("param%0d", k), bus.o_param[k*WIDTH +: WIDTH], m_param[k]);
        end
        chk("busy", bus.o_busy, m_active);
        chk("done", bus.o_done, m_done);
        chk("overrun", bus.o_overrun, m_overrun);
    endtask

    task automatic cyc(input bit strobe);
        bus.i_sample_strobe = strobe;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.i_sample_strobe = 1'b0;
        check_all();
    endtask

    task automatic sweep();
        cyc(1'b1);
        repeat (NCH + 1) cyc(1'b0);
    endtask

    task automatic set_tgt(input int k, input logic [WIDTH-1:0] v);
        bus.i_target[k*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [WIDTH-1:0] ch(input int k);
        return bus.o_param[k*WIDTH +: WIDTH];
    endfunction

    initial begin
        int n_busy;
        int n_done;
        int n_ovr;
        int d1;
        int d2;
        rst_n               = 1'b0;
        bus.i_target        = '1;
        bus.i_sample_strobe = 1'b0;
`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
        bus.i_bypass        = '0;
`endif
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_param", bus.o_param, '0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);

        rst_n        = 1'b1;
        bus.i_target = '0;
        set_tgt(0, 32'h100);
        cyc(1'b1);
        cyc(1'b0);
        chk("ramp_first", ch(0), 32'h10);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        chk("ramp_done", bus.o_done, 1'b1);
        cyc(1'b0);
        sweep();
        chk("ramp_second", ch(0), 32'h1F);

        set_tgt(1, 32'h5);
        for (int i = 1; i <= 5; i++) begin
            sweep();
            chk($sformatf("minstep_%0d", i), ch(1), 32'(i));
        end
        sweep();
        chk("minstep_hold", ch(1), 32'h5);

        set_tgt(2, 32'h100);
        for (int i = 0; i < 300 && m_param[2] != 32'h100; i++) sweep();
        chk("down_settled", ch(2), 32'h100);
        set_tgt(2, 32'h0);
        sweep();
        chk("down_first", ch(2), 32'hF0);
        sweep();
        chk("down_second", ch(2), 32'hE1);

        n_busy = 0; n_done = 0; n_ovr = 0; d1 = -1; d2 = -1;
        for (int t = 0; t < 12; t++) begin
            cyc((t == 0) || (t == 2));
            if (bus.o_busy) n_busy++;
            if (bus.o_overrun) n_ovr++;
            if (bus.o_done) begin
                n_done++;
                if (d1 < 0) d1 = t; else d2 = t;
            end
        end
        chk("ovr_pulses", 64'(n_ovr), 64'd1);
        chk("ovr_done_pulses", 64'(n_done), 64'd2);
        chk("ovr_done_gap", 64'(d2 - d1), 64'd4);
        chk("ovr_busy_cycles", 64'(n_busy), 64'd8);

        bus.i_target = '0;
        set_tgt(0, 32'h100);
        cyc(1'b1);
        cyc(1'b0);
        rst_n = 1'b0;
        cyc(1'b0);
        chk("midrst_param", bus.o_param, '0);
        chk("midrst_busy", bus.o_busy, 1'b0);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (6) begin
            cyc(1'b0);
            if (bus.o_done) n_done++;
        end
        chk("midrst_no_done", 64'(n_done), 64'd0);
        cyc(1'b1);
        cyc(1'b0);
        chk("midrst_ramp", ch(0), 32'h10);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        chk("midrst_done", bus.o_done, 1'b1);

        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) set_tgt($urandom_range(0, NCH-1), $urandom);
                else set_tgt($urandom_range(0, NCH-1), 32'($urandom_range(0, 40)));
            end
`ifdef PARAM_SLEW_LIMITER_BYPASS_EN
            if ($urandom_range(0, 15) == 0) bus.i_bypass = NCH'($urandom);
`endif
            rst_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 4) == 0);
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
